// File: rtl/disp_scan_ctrl.sv
// ============================================================================
//  Module   : disp_scan_ctrl
//  Purpose  : 4-digit multiplexed 7-segment scan controller with anti-ghost
//             blanking, registered hex decode and frame tick.
//  Options  : DISP_BRIGHT_EN - adds the 'bright' port and on-time dimming.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_scan_ctrl #(
    parameter int DWELL_CYC = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [3:0] ad_in,
`ifdef DISP_BRIGHT_EN
    input  logic [1:0] bright,
`endif
    output logic [1:0] seg_sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int          c_ON_CYC     = DWELL_CYC - BLANK_CYC;
    localparam logic [15:0] c_BLANK_LAST = 16'(BLANK_CYC - 1);
    localparam logic [15:0] c_ON_LAST    = 16'(c_ON_CYC - 1);

    localparam logic [0:0]  c_ST_BLANK   = 1'b0;
    localparam logic [0:0]  c_ST_ON      = 1'b1;

    logic [0:0]  r_state;
    logic [15:0] r_cnt;
    logic [1:0]  r_seg_sel;
    logic [6:0]  r_seg_dec;
    logic        r_frame_tick;

    logic [6:0]  w_seg_dec;
    logic        w_on;
    logic        w_an_gate;
    logic [3:0]  w_an_digit;

    // Active-low hex font, {a,b,c,d,e,f,g}
    always_comb begin
        w_seg_dec = 7'h7F;
        case (ad_in)
            4'h0: w_seg_dec = 7'b0000001;
            4'h1: w_seg_dec = 7'b1001111;
            4'h2: w_seg_dec = 7'b0010010;
            4'h3: w_seg_dec = 7'b0000110;
            4'h4: w_seg_dec = 7'b1001100;
            4'h5: w_seg_dec = 7'b0100100;
            4'h6: w_seg_dec = 7'b0100000;
            4'h7: w_seg_dec = 7'b0001111;
            4'h8: w_seg_dec = 7'b0000000;
            4'h9: w_seg_dec = 7'b0000100;
            4'hA: w_seg_dec = 7'b0001000;
            4'hB: w_seg_dec = 7'b1100000;
            4'hC: w_seg_dec = 7'b0110001;
            4'hD: w_seg_dec = 7'b1000010;
            4'hE: w_seg_dec = 7'b0110000;
            4'hF: w_seg_dec = 7'b0111000;
        endcase
    end

    // Slot sequencer: BLANK dead time, then ON; digit advances only at ON end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_BLANK;
            r_cnt        <= 16'd0;
            r_seg_sel    <= 2'd0;
            r_frame_tick <= 1'b0;
        end else if (!en) begin
            r_state      <= c_ST_BLANK;
            r_cnt        <= 16'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            case (r_state)
                c_ST_BLANK: begin
                    if (r_cnt == c_BLANK_LAST) begin
                        r_state <= c_ST_ON;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                    end
                end
                c_ST_ON: begin
                    if (r_cnt == c_ON_LAST) begin
                        r_state      <= c_ST_BLANK;
                        r_cnt        <= 16'd0;
                        r_seg_sel    <= r_seg_sel + 2'd1;
                        r_frame_tick <= (r_seg_sel == 2'd3);
                    end else begin
                        r_cnt        <= r_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg_dec <= 7'h7F;
        end else begin
            r_seg_dec <= w_seg_dec;
        end
    end

`ifdef DISP_BRIGHT_EN
    logic [31:0] w_lit_len;

    // Anodes stay lit for the first (bright+1)/4 of the ON phase
    always_comb begin
        w_lit_len = ((32'(bright) + 32'd1) * 32'(c_ON_CYC)) >> 2;
        w_an_gate = ({16'd0, r_cnt} < w_lit_len);
    end
`else
    assign w_an_gate = 1'b1;
`endif

    always_comb begin
        w_an_digit = 4'hF;
        case (r_seg_sel)
            2'd0: w_an_digit = 4'b1110;
            2'd1: w_an_digit = 4'b1101;
            2'd2: w_an_digit = 4'b1011;
            2'd3: w_an_digit = 4'b0111;
        endcase
    end

    // Outputs derive from registered state so async reset darkens them at once
    assign w_on       = (r_state == c_ST_ON);
    assign an         = (w_on && w_an_gate) ? w_an_digit : 4'hF;
    assign seg        = w_on ? r_seg_dec : 7'h7F;
    assign dp         = !(w_on && (r_seg_sel == 2'd2));
    assign seg_sel    = r_seg_sel;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl (DWELL_CYC=8, BLANK_CYC=2).
`default_nettype none

module tb_disp_scan_ctrl;

    localparam int DW = 8;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [3:0] ad_in;
    logic [1:0] seg_sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;
`ifdef DISP_BRIGHT_EN
    logic [1:0] bright;
`endif

    disp_scan_ctrl #(.DWELL_CYC(DW), .BLANK_CYC(BL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .ad_in      (ad_in),
`ifdef DISP_BRIGHT_EN
        .bright     (bright),
`endif
        .seg_sel    (seg_sel),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } vec_t;

    vec_t       tbl [16];
    logic [3:0] an_tbl [4];
    logic [6:0] exp_q [$];
    int         vi = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit lit_ok(input int on_idx);
`ifdef DISP_BRIGHT_EN
        return on_idx < (((int'(bright) + 1) * (DW - BL)) / 4);
`else
        return on_idx >= 0;
`endif
    endfunction

    // Compare one observation, then queue the seg value the next one must show
    task automatic step(input logic [3:0] e_an, input logic [1:0] e_sel, input logic e_ft,
                        input logic e_on, input logic nxt);
        logic [6:0] e_seg;
        chk("an", an, e_an);
        chk("seg_sel", seg_sel, e_sel);
        chk("dp", dp, (e_on && e_sel == 2'd2) ? 0 : 1);
        chk("frame_tick", frame_tick, e_ft);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: empty queue, seg got %0h", seg);
        end else begin
            e_seg = exp_q.pop_front();
            chk("seg", seg, e_seg);
        end
        exp_q.push_back(nxt ? tbl[ad_in].seg : 7'h7F);
        @(negedge clk);
    endtask

    // Observation k counts clock edges since the scan (re)started from cnt=0
    task automatic free_step(input int k);
        int         pos;
        int         sel;
        logic       on;
        logic       nxt;
        logic [3:0] e_an;
        pos  = k % DW;
        sel  = (k / DW) % 4;
        on   = (pos >= BL);
        nxt  = (((k + 1) % DW) >= BL);
        e_an = (on && lit_ok(pos - BL)) ? an_tbl[sel] : 4'hF;
        if (nxt) begin
            ad_in = tbl[vi % 16].nib;
            vi++;
        end else begin
            ad_in = 4'($urandom_range(0, 15));
        end
        step(e_an, 2'(sel), (k > 0) && (k % (4 * DW) == 0), on, nxt);
    endtask

    initial begin
        tbl[0]  = '{4'h0, 7'b0000001};
        tbl[1]  = '{4'h1, 7'b1001111};
        tbl[2]  = '{4'h2, 7'b0010010};
        tbl[3]  = '{4'h3, 7'b0000110};
        tbl[4]  = '{4'h4, 7'b1001100};
        tbl[5]  = '{4'h5, 7'b0100100};
        tbl[6]  = '{4'h6, 7'b0100000};
        tbl[7]  = '{4'h7, 7'b0001111};
        tbl[8]  = '{4'h8, 7'b0000000};
        tbl[9]  = '{4'h9, 7'b0000100};
        tbl[10] = '{4'hA, 7'b0001000};
        tbl[11] = '{4'hB, 7'b1100000};
        tbl[12] = '{4'hC, 7'b0110001};
        tbl[13] = '{4'hD, 7'b1000010};
        tbl[14] = '{4'hE, 7'b0110000};
        tbl[15] = '{4'hF, 7'b0111000};
        an_tbl[0] = 4'b1110;
        an_tbl[1] = 4'b1101;
        an_tbl[2] = 4'b1011;
        an_tbl[3] = 4'b0111;

        reset_n = 1'b0;
        en      = 1'b0;
        ad_in   = 4'h0;
`ifdef DISP_BRIGHT_EN
        bright  = 2'd3;
`endif
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_seg_sel", seg_sel, 2'd0);
        chk("rst_dp", dp, 1'b1);
        chk("rst_frame_tick", frame_tick, 1'b0);

        // Free-running scan with the decode table swept across ON cycles
        reset_n = 1'b1;
        en      = 1'b1;
        exp_q.push_back(7'h7F);
        for (int k = 0; k < 84; k++) free_step(k);

        // Observation 84: ON of seg_sel=10; reset must act without a clock edge
        chk("pre_rst_an", an, 4'b1011);
        chk("pre_rst_dp", dp, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_an", an, 4'hF);
        chk("async_rst_seg", seg, 7'h7F);
        chk("async_rst_seg_sel", seg_sel, 2'd0);
        chk("async_rst_dp", dp, 1'b1);
        chk("async_rst_frame_tick", frame_tick, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);

        // Enable drop at third ON cycle of seg_sel=01, then restore
        reset_n = 1'b1;
        exp_q.push_back(7'h7F);
        for (int k = 0; k < 12; k++) free_step(k);
        en    = 1'b0;
        ad_in = 4'h5;
        step(4'b1101, 2'd1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(4'hF, 2'd1, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        step(4'hF, 2'd1, 1'b0, 1'b0, 1'b0);
        step(4'hF, 2'd1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b1101, 2'd1, 1'b0, 1'b1, i < 5);
        step(4'hF, 2'd2, 1'b0, 1'b0, 1'b0);

`ifdef DISP_BRIGHT_EN
        // Dimming: bright=0 lights 1 of 6 ON cycles, bright=3 lights all 6
        bright  = 2'd0;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(7'h7F);
        for (int k = 0; k < 18; k++) begin
            if (k == 9) bright = 2'd3;
            free_step(k);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
- REQ-001: Parameter DWELL_CYC, default 50000: total clock cycles per digit slot; 16-bit range; SHALL satisfy DWELL_CYC > BLANK_CYC.
- REQ-002: Parameter BLANK_CYC, default 500: anti-ghost dead-time cycles at the start of each slot; SHALL be >= 1.
- REQ-003: clk  in  1  sole clock; all state SHALL update on rising edge.
- REQ-004: reset_n  in  1  asynchronous, active-low reset.
- REQ-005: en  in  1  scan enable; 0 = display dark and scan frozen.
- REQ-006: ad_in  in  4  nibble returned by the address/data 4-to-1 mux for the current seg_sel.
- REQ-007: seg_sel  out  2  digit select driven to the address/data mux (00=S_lo, 01=S_hi, 10=R_lo, 11=R_hi).
- REQ-008: an  out  4  digit anodes, active-low; an[i] drives digit i.
- REQ-009: seg  out  7  cathodes, active-low, seg[6:0] = {a,b,c,d,e,f,g}.
- REQ-010: dp  out  1  decimal point, active-low.
- REQ-011: frame_tick  out  1  one-cycle pulse per completed 4-digit frame.
- REQ-012: bright  in  2  brightness level; port SHALL exist only when DISP_BRIGHT_EN is defined.

Function
- REQ-013: Two-state FSM with states BLANK and ON, plus a 16-bit slot counter cnt.
- REQ-014: BLANK: an=4'b1111, seg=7'h7F, dp=1; after BLANK_CYC cycles -> ON.
- REQ-015: ON: lasts DWELL_CYC-BLANK_CYC cycles; an = active-low one-hot of seg_sel (00->1110, 01->1101, 10->1011, 11->0111).
- REQ-016: At the end of ON, seg_sel SHALL increment modulo 4 (11 wraps to 00) and the FSM SHALL enter BLANK; seg_sel changes only at this transition.
- REQ-017: frame_tick SHALL be 1 for exactly the cycle in which seg_sel wraps 11->00; 0 otherwise.
- REQ-018: In ON, seg SHALL be a registered hex decode of ad_in with 1-cycle latency: 0->0000001, 1->1001111, 2->0010010, 3->0000110, 4->1001100, 5->0100100, 6->0100000, 7->0001111, 8->0000000, 9->0000100, A->0001000, b->1100000, C->0110001, d->1000010, E->0110000, F->0111000.
- REQ-019: In ON, dp SHALL be 0 when seg_sel=10 (R/S field separator); otherwise 1.
- REQ-020: en=0 in any state: next cycle FSM=BLANK, cnt=0, outputs dark, seg_sel held, frame_tick=0.
- REQ-021: en 0->1: a full BLANK_CYC dead time SHALL precede lighting the held seg_sel digit.
- REQ-022: ad_in changes mid-slot SHALL appear on seg after one cycle; the block applies no filtering.

Reset
- REQ-023: reset_n=0 SHALL immediately (asynchronously) force FSM=BLANK, cnt=0, seg_sel=00, an=1111, seg=7'h7F, dp=1, frame_tick=0, including mid-ON.
- REQ-024: After reset_n rises, the first slot SHALL begin with BLANK for seg_sel=00.

Configuration
- REQ-025: Macro DISP_BRIGHT_EN defined: within ON, an SHALL be enabled only for the first floor((bright+1)*(DWELL_CYC-BLANK_CYC)/4) cycles and be 1111 for the rest; seg_sel timing is unchanged.
- REQ-026: Macro undefined: bright port absent; an enabled for the whole ON phase.

Verification (DWELL_CYC=8, BLANK_CYC=2)
- REQ-027: reset_n pulsed low mid-ON at seg_sel=10 -> an=1111, seg=7F, seg_sel=00 within the same cycle, without waiting for a clk edge.
- REQ-028: en=1, ad_in=8 -> seg_sel sequence 00,01,10,11,00 every 8 cycles; each slot: an=1111 for 2 cycles, then the one-hot digit for 6 cycles; frame_tick is one cycle at the 11->00 wrap.
- REQ-029: ad_in swept 0..F during ON -> seg matches the REQ-018 table one cycle later (e.g. A->0001000, F->0111000).
- REQ-030: en dropped at cycle 3 of ON with seg_sel=01 -> an=1111 next cycle; en restored -> 2 dark cycles, then an=1101.
- REQ-031: Full frame -> dp=0 only during ON of seg_sel=10.
- REQ-032: DISP_BRIGHT_EN, bright=00 -> an active 1 of 6 ON cycles; bright=11 -> active all 6.
